// File: rtl/bus_pkg.sv
// Shared definitions for the three-way bus arbiter: owner codes, FSM states,
// default bus widths and the starvation-counter increment helper.
package bus_pkg;

    localparam int BUS_ADR_W = 20;
    localparam int BUS_DAT_W = 16;
    localparam int CNT_W     = 4;

    localparam logic [1:0] GNT_NONE = 2'd0;
    localparam logic [1:0] GNT_EU   = 2'd1;
    localparam logic [1:0] GNT_PF   = 2'd2;
    localparam logic [1:0] GNT_DM   = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic [CNT_W-1:0] lim);
        if (v >= lim) begin
            return lim;
        end else begin
            return v + 4'd1;
        end
    endfunction

endpackage

// File: rtl/bus_arb_pick.sv
// Combinational winner select: promoted DM, promoted PF, then EU > PF > DM.
// An active EU lock restricts the choice to EU and suppresses promotion.
module bus_arb_pick
    import bus_pkg::*;
(
    input  logic [2:0] i_req,
    input  logic       i_pf_starve,
    input  logic       i_dm_starve,
    input  logic       i_lock,
    output logic [1:0] o_gnt
);

    // Priority resolution; DM wins a double promotion since it has waited longest.
    always_comb begin
        o_gnt = GNT_NONE;
        if (i_lock) begin
            if (i_req[0]) begin
                o_gnt = GNT_EU;
            end else begin
                o_gnt = GNT_NONE;
            end
        end else if (i_dm_starve && i_req[2]) begin
            o_gnt = GNT_DM;
        end else if (i_pf_starve && i_req[1]) begin
            o_gnt = GNT_PF;
        end else if (i_req[0]) begin
            o_gnt = GNT_EU;
        end else if (i_req[1]) begin
            o_gnt = GNT_PF;
        end else if (i_req[2]) begin
            o_gnt = GNT_DM;
        end else begin
            o_gnt = GNT_NONE;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Shares one bus transaction engine between EU, PF and DM requesters.
// Optional atomic EU lock (eu_lock port) when BUS_ARBITER_LOCK_EN is defined.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int ADR_W        = BUS_ADR_W,
    parameter int DAT_W        = BUS_DAT_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef BUS_ARBITER_LOCK_EN
    input  logic             eu_lock,
`endif
    input  logic             eu_req,
    input  logic             pf_req,
    input  logic             dm_req,
    input  logic             eu_rw,
    input  logic             pf_rw,
    input  logic             dm_rw,
    input  logic [ADR_W-1:0] eu_adr,
    input  logic [ADR_W-1:0] pf_adr,
    input  logic [ADR_W-1:0] dm_adr,
    input  logic [DAT_W-1:0] eu_dtw,
    input  logic [DAT_W-1:0] pf_dtw,
    input  logic [DAT_W-1:0] dm_dtw,
    output logic             eu_ack,
    output logic             pf_ack,
    output logic             dm_ack,
    output logic [DAT_W-1:0] eu_dtr,
    output logic [DAT_W-1:0] pf_dtr,
    output logic [DAT_W-1:0] dm_dtr,
    output logic             bus_req,
    output logic             bus_rw,
    output logic [ADR_W-1:0] bus_adr,
    output logic [DAT_W-1:0] bus_dtw,
    input  logic             bus_ack,
    input  logic [DAT_W-1:0] bus_dtr,
    output logic [1:0]       gnt
);

    localparam logic [CNT_W-1:0] LIM = 4'(STARVE_LIMIT);

    state_t             r_state;
    state_t             w_next;
    logic [1:0]         r_gnt;
    logic [1:0]         w_win;
    logic [CNT_W-1:0]   r_pf_cnt;
    logic [CNT_W-1:0]   r_dm_cnt;
    logic               w_lock;
    logic               w_pf_starve;
    logic               w_dm_starve;
    logic               w_rw;
    logic [ADR_W-1:0]   w_adr;
    logic [DAT_W-1:0]   w_dtw;
    logic               r_eu_ack, r_pf_ack, r_dm_ack;
    logic [DAT_W-1:0]   r_eu_dtr, r_pf_dtr, r_dm_dtr;
    logic               r_bus_req, r_bus_rw;
    logic [ADR_W-1:0]   r_bus_adr;
    logic [DAT_W-1:0]   r_bus_dtw;

    assign w_pf_starve = (r_pf_cnt >= LIM);
    assign w_dm_starve = (r_dm_cnt >= LIM);

`ifdef BUS_ARBITER_LOCK_EN
    logic r_lock;

    assign w_lock = r_lock & eu_lock & eu_req;

    // Lock is armed by EU's completion and released by the first IDLE that does not honour it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock <= 1'b0;
        end else if (r_state == DONE && r_gnt == GNT_EU) begin
            r_lock <= eu_lock;
        end else if (r_state == IDLE && !w_lock) begin
            r_lock <= 1'b0;
        end else begin
            r_lock <= r_lock;
        end
    end
`else
    assign w_lock = 1'b0;
`endif

    bus_arb_pick u_pick (
        .i_req       ({dm_req, pf_req, eu_req}),
        .i_pf_starve (w_pf_starve),
        .i_dm_starve (w_dm_starve),
        .i_lock      (w_lock),
        .o_gnt       (w_win)
    );

    // Request fields of the IDLE winner.
    always_comb begin
        w_rw  = eu_rw;
        w_adr = eu_adr;
        w_dtw = eu_dtw;
        case (w_win)
            GNT_PF: begin
                w_rw  = pf_rw;
                w_adr = pf_adr;
                w_dtw = pf_dtw;
            end
            GNT_DM: begin
                w_rw  = dm_rw;
                w_adr = dm_adr;
                w_dtw = dm_dtw;
            end
            default: begin
                w_rw  = eu_rw;
                w_adr = eu_adr;
                w_dtw = eu_dtw;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; bus_ack only matters while a transaction is issued.
    always_comb begin
        w_next = IDLE;
        case (r_state)
            IDLE:    w_next = (w_win != GNT_NONE) ? ISSUE : IDLE;
            ISSUE:   w_next = bus_ack ? DONE : ISSUE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Starvation counters: updated only at IDLE evaluations, saturating at the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pf_cnt <= 4'd0;
            r_dm_cnt <= 4'd0;
        end else if (r_state == IDLE) begin
            r_pf_cnt <= (!pf_req || w_win == GNT_PF) ? 4'd0 : sat_inc(r_pf_cnt, LIM);
            r_dm_cnt <= (!dm_req || w_win == GNT_DM) ? 4'd0 : sat_inc(r_dm_cnt, LIM);
        end else begin
            r_pf_cnt <= r_pf_cnt;
            r_dm_cnt <= r_dm_cnt;
        end
    end

    // Registered outputs: ack and read data land together in the DONE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt     <= GNT_NONE;
            r_bus_req <= 1'b0;
            r_bus_rw  <= 1'b0;
            r_bus_adr <= '0;
            r_bus_dtw <= '0;
            r_eu_ack  <= 1'b0;
            r_pf_ack  <= 1'b0;
            r_dm_ack  <= 1'b0;
            r_eu_dtr  <= '0;
            r_pf_dtr  <= '0;
            r_dm_dtr  <= '0;
        end else begin
            r_eu_ack <= 1'b0;
            r_pf_ack <= 1'b0;
            r_dm_ack <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_win != GNT_NONE) begin
                        r_gnt     <= w_win;
                        r_bus_req <= 1'b1;
                        r_bus_rw  <= w_rw;
                        r_bus_adr <= w_adr;
                        r_bus_dtw <= w_dtw;
                    end
                end
                ISSUE: begin
                    if (bus_ack) begin
                        r_bus_req <= 1'b0;
                        case (r_gnt)
                            GNT_EU: begin
                                r_eu_ack <= 1'b1;
                                r_eu_dtr <= bus_dtr;
                            end
                            GNT_PF: begin
                                r_pf_ack <= 1'b1;
                                r_pf_dtr <= bus_dtr;
                            end
                            GNT_DM: begin
                                r_dm_ack <= 1'b1;
                                r_dm_dtr <= bus_dtr;
                            end
                            default: ;
                        endcase
                    end
                end
                DONE: r_gnt <= GNT_NONE;
                default: begin
                    r_gnt     <= GNT_NONE;
                    r_bus_req <= 1'b0;
                end
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign bus_req = r_bus_req;
    assign bus_rw  = r_bus_rw;
    assign bus_adr = r_bus_adr;
    assign bus_dtw = r_bus_dtw;
    assign eu_ack  = r_eu_ack;
    assign pf_ack  = r_pf_ack;
    assign dm_ack  = r_dm_ack;
    assign eu_dtr  = r_eu_dtr;
    assign pf_dtr  = r_pf_dtr;
    assign dm_dtr  = r_dm_dtr;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios followed by random
// traffic, checked against a transaction-level priority/starvation model.
module tb_bus_arbiter;

    localparam int LIM = 4;

    typedef struct {
        logic        rw;
        logic [19:0] adr;
        logic [15:0] dtw;
    } tx_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        eu_req = 1'b0, pf_req = 1'b0, dm_req = 1'b0;
    logic        eu_rw = 1'b0, pf_rw = 1'b0, dm_rw = 1'b0;
    logic [19:0] eu_adr = '0, pf_adr = '0, dm_adr = '0;
    logic [15:0] eu_dtw = '0, pf_dtw = '0, dm_dtw = '0;
    logic        eu_ack, pf_ack, dm_ack;
    logic [15:0] eu_dtr, pf_dtr, dm_dtr;
    logic        bus_req, bus_rw;
    logic [19:0] bus_adr;
    logic [15:0] bus_dtw;
    logic        bus_ack = 1'b0;
    logic [15:0] bus_dtr = '0;
    logic [1:0]  gnt;

    bus_arbiter #(.ADR_W(20), .DAT_W(16), .STARVE_LIMIT(LIM)) dut (
`ifdef BUS_ARBITER_LOCK_EN
        .eu_lock (1'b0),
`endif
        .clk(clk), .rst_n(rst_n),
        .eu_req(eu_req), .pf_req(pf_req), .dm_req(dm_req),
        .eu_rw(eu_rw), .pf_rw(pf_rw), .dm_rw(dm_rw),
        .eu_adr(eu_adr), .pf_adr(pf_adr), .dm_adr(dm_adr),
        .eu_dtw(eu_dtw), .pf_dtw(pf_dtw), .dm_dtw(dm_dtw),
        .eu_ack(eu_ack), .pf_ack(pf_ack), .dm_ack(dm_ack),
        .eu_dtr(eu_dtr), .pf_dtr(pf_dtr), .dm_dtr(dm_dtr),
        .bus_req(bus_req), .bus_rw(bus_rw), .bus_adr(bus_adr), .bus_dtw(bus_dtw),
        .bus_ack(bus_ack), .bus_dtr(bus_dtr), .gnt(gnt)
    );

    always #5 clk = ~clk;

    tx_t         q[3][$];
    int          n_vec = 0;
    int          n_err = 0;
    int          pc = 0, dc = 0;
    int          owner = 0;
    bit          exp_ack = 1'b0;
    logic [15:0] ack_data = '0;
    logic [15:0] ref_dtr[3];
    bit          dtr_valid[3];
    bit          prev_idle = 1'b1;
    int          rsp_cnt = 0;
    bit          rsp_rand = 1'b0;
    int          fix_delay = 0;
    logic [15:0] fix_data = '0;
    bit          spur_en = 1'b0;
    bit          force_spur = 1'b0;
    int          grant_log[$];
    int          hi_cycles = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference arbitration from the priority rules.
    function automatic int model_pick(bit e, bit p, bit d);
        if (d && dc >= LIM) return 3;
        if (p && pc >= LIM) return 2;
        if (e) return 1;
        if (p) return 2;
        if (d) return 3;
        return 0;
    endfunction

    function automatic logic [15:0] dtr_of(int i);
        if (i == 0) return eu_dtr;
        if (i == 1) return pf_dtr;
        return dm_dtr;
    endfunction

    task automatic do_apply();
        eu_req = (q[0].size() > 0);
        pf_req = (q[1].size() > 0);
        dm_req = (q[2].size() > 0);
        if (eu_req) begin eu_rw = q[0][0].rw; eu_adr = q[0][0].adr; eu_dtw = q[0][0].dtw; end
        if (pf_req) begin pf_rw = q[1][0].rw; pf_adr = q[1][0].adr; pf_dtw = q[1][0].dtw; end
        if (dm_req) begin dm_rw = q[2][0].rw; dm_adr = q[2][0].adr; dm_dtw = q[2][0].dtw; end
    endtask

    task automatic push(input int r, input logic rw, input logic [19:0] adr, input logic [15:0] dtw);
        tx_t t;
        t.rw = rw; t.adr = adr; t.dtw = dtw;
        q[r].push_back(t);
    endtask

    // One clock: check outputs at the falling edge, then play requesters and bus slave.
    task automatic cycle();
        int         w;
        logic [2:0] e3;
        bit         was_ack;
        @(negedge clk);
        was_ack = exp_ack;
        e3 = 3'b000;
        if (exp_ack) e3 = 3'(1 << (owner - 1));
        chk("acks", 32'({dm_ack, pf_ack, eu_ack}), 32'(e3));
        if (exp_ack) begin
            ref_dtr[owner-1]   = ack_data;
            dtr_valid[owner-1] = 1'b1;
            chk("gnt_done", 32'(gnt), 32'(owner));
            chk("busreq_done", 32'(bus_req), 32'(0));
            void'(q[owner-1].pop_front());
            owner   = 0;
            exp_ack = 1'b0;
        end
        for (int i = 0; i < 3; i++) begin
            if (dtr_valid[i]) chk("dtr_hold", 32'(dtr_of(i)), 32'(ref_dtr[i]));
        end
        if (prev_idle) begin
            w = model_pick(eu_req === 1'b1, pf_req === 1'b1, dm_req === 1'b1);
            chk("grant_latency", 32'(bus_req), 32'(w != 0));
            chk("gnt", 32'(gnt), 32'(w));
            if (w != 0 && bus_req === 1'b1) begin
                chk("grant_rw", 32'(bus_rw), 32'(q[w-1][0].rw));
                chk("grant_adr", 32'(bus_adr), 32'(q[w-1][0].adr));
                chk("grant_dtw", 32'(bus_dtw), 32'(q[w-1][0].dtw));
                owner = w;
                grant_log.push_back(w);
                rsp_cnt = rsp_rand ? int'($urandom_range(0, 3)) : fix_delay;
                hi_cycles = 0;
            end
            pc = (pf_req !== 1'b1 || w == 2) ? 0 : ((pc >= LIM) ? LIM : pc + 1);
            dc = (dm_req !== 1'b1 || w == 3) ? 0 : ((dc >= LIM) ? LIM : dc + 1);
        end else if (bus_req === 1'b1) begin
            if (owner == 0) begin
                chk("stray_bus_req", 32'(bus_req), 32'(0));
            end else begin
                chk("hold_gnt", 32'(gnt), 32'(owner));
                chk("hold_rw", 32'(bus_rw), 32'(q[owner-1][0].rw));
                chk("hold_adr", 32'(bus_adr), 32'(q[owner-1][0].adr));
                chk("hold_dtw", 32'(bus_dtw), 32'(q[owner-1][0].dtw));
            end
        end else if (!was_ack) begin
            chk("gnt_idle", 32'(gnt), 32'(0));
        end
        prev_idle = (bus_req === 1'b0) && !was_ack;
        if (bus_req === 1'b1 && owner != 0) begin
            hi_cycles++;
            if (rsp_cnt == 0) begin
                ack_data = rsp_rand ? 16'($urandom) : fix_data;
                bus_ack  = 1'b1;
                bus_dtr  = ack_data;
                exp_ack  = 1'b1;
            end else begin
                rsp_cnt--;
                bus_ack = 1'b0;
                bus_dtr = 16'($urandom);
            end
        end else begin
            bus_ack = force_spur || (spur_en && $urandom_range(0, 5) == 0);
            bus_dtr = 16'($urandom);
        end
        do_apply();
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while ((q[0].size() + q[1].size() + q[2].size() != 0 || owner != 0 || exp_ack) && n < bound) begin
            cycle();
            n++;
        end
        chk("drain_timeout", 32'(n < bound), 32'(1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

    initial begin
        bit seen;
        for (int i = 0; i < 3; i++) begin ref_dtr[i] = '0; dtr_valid[i] = 1'b0; end

        // Reset values.
        repeat (3) @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'(0));
        chk("rst_bus_req", 32'(bus_req), 32'(0));
        chk("rst_bus_rw", 32'(bus_rw), 32'(0));
        chk("rst_bus_adr", 32'(bus_adr), 32'(0));
        chk("rst_bus_dtw", 32'(bus_dtw), 32'(0));
        chk("rst_acks", 32'({dm_ack, pf_ack, eu_ack}), 32'(0));
        rst_n = 1'b1;

        // Single EU read.
        push(0, 1'b0, 20'h12345, 16'h0000);
        fix_delay = 0; fix_data = 16'hBEEF;
        do_apply();
        cycle();
        chk("t1_bus_req", 32'(bus_req), 32'(1));
        chk("t1_bus_adr", 32'(bus_adr), 32'h12345);
        chk("t1_bus_rw", 32'(bus_rw), 32'(0));
        cycle();
        chk("t1_eu_ack", 32'(eu_ack), 32'(1));
        chk("t1_eu_dtr", 32'(eu_dtr), 32'hBEEF);
        chk("t1_other_acks", 32'({dm_ack, pf_ack}), 32'(0));
        cycle();
        chk("t1_ack_one_cycle", 32'(eu_ack), 32'(0));

        // PF write with a slow bus slave.
        push(1, 1'b1, 20'h00010, 16'hA5A5);
        fix_delay = 4; fix_data = 16'h0000;
        do_apply();
        cycle();
        chk("t2_bus_dtw", 32'(bus_dtw), 32'hA5A5);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cycle();
            if (pf_ack === 1'b1) seen = 1'b1;
        end
        chk("t2_pf_ack", 32'(seen), 32'(1));
        chk("t2_req_cycles", 32'(hi_cycles), 32'(5));

        // Spurious bus_ack while idle.
        force_spur = 1'b1;
        repeat (3) cycle();
        force_spur = 1'b0;
        cycle();
        chk("t3_no_ack", 32'({dm_ack, pf_ack, eu_ack}), 32'(0));

        // All three requesting, EU keeps re-requesting.
        fix_delay = 0; fix_data = 16'h5A5A;
        grant_log.delete();
        for (int i = 0; i < 6; i++) push(0, 1'b0, 20'(32'h100 + i), 16'h0000);
        push(1, 1'b0, 20'h20000, 16'h0000);
        push(2, 1'b1, 20'h30000, 16'h1111);
        do_apply();
        drain(200);
        chk("t4_grants", 32'(grant_log.size()), 32'(8));
        if (grant_log.size() >= 5) begin
            chk("t4_g0", 32'(grant_log[0]), 32'(1));
            chk("t4_g1", 32'(grant_log[1]), 32'(1));
            chk("t4_g2", 32'(grant_log[2]), 32'(1));
            chk("t4_g3", 32'(grant_log[3]), 32'(1));
            chk("t4_g4_dm_promoted", 32'(grant_log[4]), 32'(3));
        end

        // Reset in the middle of an issued transaction.
        push(2, 1'b0, 20'h0ABCD, 16'h0000);
        fix_delay = 20;
        do_apply();
        cycle();
        cycle();
        chk("t5_in_issue", 32'(bus_req), 32'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_bus_req", 32'(bus_req), 32'(0));
        chk("t5_rst_gnt", 32'(gnt), 32'(0));
        for (int i = 0; i < 3; i++) begin q[i].delete(); dtr_valid[i] = 1'b0; end
        do_apply();
        bus_ack = 1'b0;
        owner = 0; exp_ack = 1'b0; pc = 0; dc = 0; prev_idle = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) cycle();
        push(2, 1'b0, 20'h0ABCD, 16'h0000);
        fix_delay = 1; fix_data = 16'h1234;
        do_apply();
        drain(50);
        chk("t5_dm_dtr", 32'(dm_dtr), 32'h1234);

        // Random traffic against the model.
        rsp_rand = 1'b1;
        spur_en  = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                int r;
                r = int'($urandom_range(0, 2));
                if (q[r].size() < 3) push(r, 1'($urandom), 20'($urandom), 16'($urandom));
                do_apply();
            end
            cycle();
        end
        drain(400);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
